// File: rtl/writeback_checker_pkg.sv
// Shared types for the write-back trace checker: FSM state encoding and failure codes.
package writeback_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISMATCH = 2'd1,
        FC_TIMEOUT  = 2'd2,
        FC_LENGTH   = 2'd3
    } fail_code_t;

endpackage

// File: rtl/writeback_checker_trace_memory.sv
// Expected-trace storage: one synchronous write port, one asynchronous read port, no reset.
module writeback_checker_trace_memory
    import writeback_checker_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ENTRY_WIDTH = 69,
    parameter int unsigned INDEX_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] write_index,
    input  logic [ENTRY_WIDTH-1:0] write_entry,
    input  logic [INDEX_WIDTH-1:0] read_index,
    output logic [ENTRY_WIDTH-1:0] read_entry
);

    logic [ENTRY_WIDTH-1:0] entries [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            entries[write_index] <= write_entry;
        end
    end

    assign read_entry = entries[read_index];

endmodule

// File: rtl/writeback_checker.sv
// Order-based register write-back checker: compares each non-zero-register write
// against a preloaded masked trace, with per-write timeout and sticky status.
module writeback_checker
    import writeback_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned TIMEOUT       = 64,
    parameter int unsigned INDEX_WIDTH   = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     trace_write_enable,
    input  logic [INDEX_WIDTH-1:0]   trace_write_index,
    input  logic [ADDRESS_WIDTH-1:0] trace_write_address,
    input  logic [DATA_WIDTH-1:0]    trace_write_data,
    input  logic [DATA_WIDTH-1:0]    trace_write_mask,
    input  logic [INDEX_WIDTH:0]     trace_length,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [1:0]               fail_code,
    output logic [INDEX_WIDTH-1:0]   fail_index,
    output logic [ADDRESS_WIDTH-1:0] fail_address,
    output logic [DATA_WIDTH-1:0]    fail_data
);

    localparam int unsigned LENGTH_WIDTH = INDEX_WIDTH + 1;
    localparam int unsigned TIMER_WIDTH  = $clog2(TIMEOUT);
    localparam int unsigned ENTRY_WIDTH  = ADDRESS_WIDTH + 2 * DATA_WIDTH;

    state_t                   state;
    logic [INDEX_WIDTH-1:0]   pointer;
    logic [TIMER_WIDTH-1:0]   timer;
    logic [LENGTH_WIDTH-1:0]  length;

    logic [ENTRY_WIDTH-1:0]   expected_entry;
    logic [ADDRESS_WIDTH-1:0] expected_address;
    logic [DATA_WIDTH-1:0]    expected_data;
    logic [DATA_WIDTH-1:0]    expected_mask;
    logic                     load_enable;
    logic                     considered;
    logic                     matched;
    logic                     last_entry;
    logic                     timer_expired;

    assign load_enable = trace_write_enable && (state == ST_IDLE);

    writeback_checker_trace_memory #(
        .DEPTH       (DEPTH),
        .ENTRY_WIDTH (ENTRY_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_trace_memory (
        .clock        (clock),
        .write_enable (load_enable),
        .write_index  (trace_write_index),
        .write_entry  ({trace_write_address, trace_write_data, trace_write_mask}),
        .read_index   (pointer),
        .read_entry   (expected_entry)
    );

    assign expected_address = expected_entry[ENTRY_WIDTH-1 -: ADDRESS_WIDTH];
    assign expected_data    = expected_entry[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign expected_mask    = expected_entry[DATA_WIDTH-1:0];

    // Writes to r0 are architecturally discarded, so they never advance the trace.
    assign considered    = write_enable && (write_address != '0);
    assign matched       = (write_address == expected_address) &&
                           (((write_data ^ expected_data) & expected_mask) == '0);
    assign last_entry    = ({1'b0, pointer} == (length - LENGTH_WIDTH'(1)));
    assign timer_expired = (timer == TIMER_WIDTH'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            pointer      <= '0;
            timer        <= '0;
            length       <= '0;
            busy         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            fail_code    <= FC_NONE;
            fail_index   <= '0;
            fail_address <= '0;
            fail_data    <= '0;
        end else if (clear) begin
            state        <= ST_IDLE;
            pointer      <= '0;
            timer        <= '0;
            busy         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            fail_code    <= FC_NONE;
            fail_index   <= '0;
            fail_address <= '0;
            fail_data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (trace_length == '0) begin
                            state <= ST_PASS;
                            pass  <= 1'b1;
                        end else if (trace_length > LENGTH_WIDTH'(DEPTH)) begin
                            state      <= ST_FAIL;
                            fail       <= 1'b1;
                            fail_code  <= FC_LENGTH;
                            fail_index <= '0;
                        end else begin
                            state   <= ST_RUN;
                            busy    <= 1'b1;
                            length  <= trace_length;
                            pointer <= '0;
                            timer   <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (considered) begin
                        if (matched) begin
                            pointer <= pointer + INDEX_WIDTH'(1);
                            timer   <= '0;
                            if (last_entry) begin
                                state <= ST_PASS;
                                busy  <= 1'b0;
                                pass  <= 1'b1;
                            end
                        end else begin
                            state        <= ST_FAIL;
                            busy         <= 1'b0;
                            fail         <= 1'b1;
                            fail_code    <= FC_MISMATCH;
                            fail_index   <= pointer;
                            fail_address <= write_address;
                            fail_data    <= write_data;
                        end
                    end else if (timer_expired) begin
                        state      <= ST_FAIL;
                        busy       <= 1'b0;
                        fail       <= 1'b1;
                        fail_code  <= FC_TIMEOUT;
                        fail_index <= pointer;
                    end else begin
                        timer <= timer + TIMER_WIDTH'(1);
                    end
                end
                default: begin
                    // PASS and FAIL hold until clear or reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_checker.sv
// Directed bench for writeback_checker with a trace-level reference model checked every cycle.
module tb_writeback_checker;

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned IW      = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          trace_write_enable = 1'b0;
    logic [IW-1:0] trace_write_index = '0;
    logic [AW-1:0] trace_write_address = '0;
    logic [DW-1:0] trace_write_data = '0;
    logic [DW-1:0] trace_write_mask = '0;
    logic [IW:0]   trace_length = '0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          write_enable = 1'b0;
    logic [AW-1:0] write_address = '0;
    logic [DW-1:0] write_data = '0;
    logic          busy, pass, fail;
    logic [1:0]    fail_code;
    logic [IW-1:0] fail_index;
    logic [AW-1:0] fail_address;
    logic [DW-1:0] fail_data;

    int total = 0;
    int bad   = 0;

    writeback_checker #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .DEPTH         (DEPTH),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .trace_write_enable  (trace_write_enable),
        .trace_write_index   (trace_write_index),
        .trace_write_address (trace_write_address),
        .trace_write_data    (trace_write_data),
        .trace_write_mask    (trace_write_mask),
        .trace_length        (trace_length),
        .start               (start),
        .clear               (clear),
        .write_enable        (write_enable),
        .write_address       (write_address),
        .write_data          (write_data),
        .busy                (busy),
        .pass                (pass),
        .fail                (fail),
        .fail_code           (fail_code),
        .fail_index          (fail_index),
        .fail_address        (fail_address),
        .fail_data           (fail_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: trace as plain arrays, status as flags, idle cycles counted since last match.
    logic [AW-1:0] m_addr [DEPTH];
    logic [DW-1:0] m_data [DEPTH];
    logic [DW-1:0] m_mask [DEPTH];
    int  m_len, m_pos, m_quiet;
    bit  m_busy, m_pass, m_fail;
    int  m_code, m_idx, m_faddr;
    logic [DW-1:0] m_fdata;

    task automatic model_clear();
        m_busy = 0; m_pass = 0; m_fail = 0;
        m_code = 0; m_idx = 0; m_faddr = 0; m_fdata = '0;
        m_pos = 0; m_quiet = 0;
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_clear();
            m_len = 0;
        end else begin
            bit idle;
            idle = !m_busy && !m_pass && !m_fail;
            if (idle && trace_write_enable) begin
                m_addr[trace_write_index] = trace_write_address;
                m_data[trace_write_index] = trace_write_data;
                m_mask[trace_write_index] = trace_write_mask;
            end
            if (clear) begin
                model_clear();
            end else if (idle && start) begin
                if (trace_length == 0) m_pass = 1;
                else if (int'(trace_length) > DEPTH) begin
                    m_fail = 1; m_code = 3; m_idx = 0;
                end else begin
                    m_busy = 1; m_len = int'(trace_length); m_pos = 0; m_quiet = 0;
                end
            end else if (m_busy) begin
                if (write_enable && write_address != 0) begin
                    if (write_address == m_addr[m_pos] &&
                        (write_data & m_mask[m_pos]) == (m_data[m_pos] & m_mask[m_pos])) begin
                        m_pos++;
                        m_quiet = 0;
                        if (m_pos == m_len) begin m_busy = 0; m_pass = 1; end
                    end else begin
                        m_busy = 0; m_fail = 1; m_code = 1; m_idx = m_pos;
                        m_faddr = int'(write_address); m_fdata = write_data;
                    end
                end else begin
                    m_quiet++;
                    if (m_quiet == TIMEOUT) begin
                        m_busy = 0; m_fail = 1; m_code = 2; m_idx = m_pos;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        check("model busy", 32'(busy), 32'(m_busy));
        check("model pass", 32'(pass), 32'(m_pass));
        check("model fail", 32'(fail), 32'(m_fail));
        check("model fail_code", 32'(fail_code), 32'(m_code));
        check("model fail_index", 32'(fail_index), 32'(m_idx));
        check("model fail_address", 32'(fail_address), 32'(m_faddr));
        check("model fail_data", fail_data, m_fdata);
    end

    task automatic cycle();
        @(negedge clock);
    endtask

    task automatic load(input int idx, input int addr, input logic [DW-1:0] data, input logic [DW-1:0] mask);
        trace_write_enable = 1'b1;
        trace_write_index = IW'(idx);
        trace_write_address = AW'(addr);
        trace_write_data = data;
        trace_write_mask = mask;
        cycle();
        trace_write_enable = 1'b0;
    endtask

    task automatic cpu_write(input int addr, input logic [DW-1:0] data);
        write_enable = 1'b1;
        write_address = AW'(addr);
        write_data = data;
        cycle();
        write_enable = 1'b0;
    endtask

    task automatic begin_run(input int len);
        trace_length = (IW + 1)'(len);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic load_logic_trace();
        load(0, 1, 32'h0101_0000, 32'hFFFF_FFFF);
        load(1, 1, 32'h0101_0101, 32'hFFFF_FFFF);
        load(2, 2, 32'h0101_1101, 32'hFFFF_FFFF);
        load(3, 4, 32'h0000_FF00, 32'hFFFF_FFFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        check("reset busy", 32'(busy), 0);
        check("reset pass", 32'(pass), 0);
        check("reset fail", 32'(fail), 0);

        // Logic-sequence pass, with idle gaps and an ignored r0 write.
        load_logic_trace();
        begin_run(4);
        check("seq busy", 32'(busy), 1);
        cpu_write(1, 32'h0101_0000);
        repeat (2) cycle();
        cpu_write(0, 32'hDEAD_BEEF);
        cpu_write(1, 32'h0101_0101);
        repeat (3) cycle();
        cpu_write(2, 32'h0101_1101);
        cycle();
        check("seq not yet pass", 32'(pass), 0);
        cpu_write(4, 32'h0000_FF00);
        check("seq pass", 32'(pass), 1);
        check("seq busy low", 32'(busy), 0);
        check("seq fail_code", 32'(fail_code), 0);
        do_clear();

        // Mask don't-care on low half.
        load(0, 3, 32'h0000_0000, 32'hFFFF_0000);
        begin_run(1);
        cpu_write(3, 32'h0000_1234);
        check("mask pass", 32'(pass), 1);
        do_clear();

        // Mismatch on second write; status must then stay frozen.
        load_logic_trace();
        begin_run(4);
        cpu_write(1, 32'h0101_0000);
        cpu_write(1, 32'h0101_0100);
        check("mm fail", 32'(fail), 1);
        check("mm code", 32'(fail_code), 1);
        check("mm index", 32'(fail_index), 1);
        check("mm address", 32'(fail_address), 1);
        check("mm data", fail_data, 32'h0101_0100);
        cpu_write(2, 32'h0101_1101);
        begin_run(4);
        check("mm sticky data", fail_data, 32'h0101_0100);
        check("mm sticky busy", 32'(busy), 0);
        do_clear();
        check("clear fail", 32'(fail), 0);

        // Timeout: exactly TIMEOUT idle edges after the matching write.
        begin_run(2);
        cpu_write(1, 32'h0101_0000);
        for (int k = 1; k <= 64; k++) begin
            cycle();
            if (k == 63) check("to early", 32'(fail), 0);
            if (k == 64) begin
                check("to fail", 32'(fail), 1);
                check("to code", 32'(fail_code), 2);
                check("to index", 32'(fail_index), 1);
                check("to address", 32'(fail_address), 0);
            end
        end
        do_clear();

        // Length boundaries.
        begin_run(0);
        check("len0 pass", 32'(pass), 1);
        do_clear();
        begin_run(17);
        check("len17 fail", 32'(fail), 1);
        check("len17 code", 32'(fail_code), 3);
        check("len17 index", 32'(fail_index), 0);
        do_clear();
        begin_run(16);
        check("len16 busy", 32'(busy), 1);
        do_clear();

        // Asynchronous reset between edges mid-RUN.
        begin_run(4);
        cpu_write(1, 32'h0101_0000);
        #2 reset = 1'b0;
        #1;
        check("areset busy", 32'(busy), 0);
        check("areset pass", 32'(pass), 0);
        check("areset fail", 32'(fail), 0);
        check("areset code", 32'(fail_code), 0);
        cycle();
        reset = 1'b1;
        cycle();

        // clear beats start while in PASS.
        begin_run(0);
        check("pre-clear pass", 32'(pass), 1);
        clear = 1'b1;
        trace_length = 5'd4;
        start = 1'b1;
        cycle();
        clear = 1'b0;
        start = 1'b0;
        check("clr+start busy", 32'(busy), 0);
        check("clr+start pass", 32'(pass), 0);
        cycle();
        check("idle busy", 32'(busy), 0);

        // Reload a new trace; a load attempted during RUN must be ignored.
        load(0, 5, 32'h1234_5678, 32'hFFFF_FFFF);
        load(1, 6, 32'h0000_00AA, 32'h0000_00FF);
        begin_run(2);
        load(1, 7, 32'h5555_5555, 32'hFFFF_FFFF);
        cpu_write(5, 32'h1234_5678);
        cpu_write(6, 32'hFFFF_FFAA);
        check("reload pass", 32'(pass), 1);
        check("reload fail", 32'(fail), 0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
